// File: rtl/bit_8_adder_pkg.sv
// Shared constants for the registered adder/subtractor.
// Build option: BIT_8_ADDER_ZERO_FLAG_EN adds the Z output.
package bit_8_adder_pkg;
  localparam int   WIDTH_DEF = 8;
  localparam logic MODE_ADD  = 1'b0;
  localparam logic MODE_SUB  = 1'b1;
endpackage

// File: rtl/bit_8_adder_full_adder.sv
// One-bit full adder cell for the ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/bit_8_adder.sv
// Registered ripple adder/subtractor with carry and signed overflow.
// Build option: BIT_8_ADDER_ZERO_FLAG_EN adds a registered zero flag Z.
module bit_8_adder
  import bit_8_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mode,
`ifdef BIT_8_ADDER_ZERO_FLAG_EN
  output logic             Z,
`endif
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ov
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   c;
  logic             ov;

  // Subtract is A + ~B + 1.
  assign bx   = B ^ {WIDTH{mode}};
  assign c[0] = (mode == MODE_SUB);

  for (genvar i = 0; i < WIDTH; i++) begin : g_rca
    full_adder u_fa (
      .a    (A[i]),
      .b    (bx[i]),
      .cin  (c[i]),
      .s    (sum[i]),
      .cout (c[i+1])
    );
  end

  assign ov = c[WIDTH] ^ c[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S    <= '0;
      Cout <= 1'b0;
      Ov   <= 1'b0;
    end else begin
      S    <= sum;
      Cout <= c[WIDTH];
      Ov   <= ov;
    end
  end

`ifdef BIT_8_ADDER_ZERO_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) Z <= 1'b0;
    else        Z <= ~|sum;
  end
`endif

endmodule

// File: tb/tb_bit_8_adder.sv
// Self-checking bench for bit_8_adder: directed table,
// reset sequences and random vectors against an arithmetic model.
module tb_bit_8_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] A, B;
  logic       mode;
  logic [7:0] S;
  logic       Cout, Ov;
`ifdef BIT_8_ADDER_ZERO_FLAG_EN
  logic       Z;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bit_8_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .mode  (mode),
`ifdef BIT_8_ADDER_ZERO_FLAG_EN
    .Z     (Z),
`endif
    .S     (S),
    .Cout  (Cout),
    .Ov    (Ov)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       m;
    logic [7:0] s;
    logic       c;
    logic       o;
  } vec_t;

  task automatic chk(input string nm, input logic [7:0] es,
                     input logic ec, input logic eo);
    checks++;
    if (S !== es || Cout !== ec || Ov !== eo) begin
      failures++;
      $display("FAIL %s: got S=%h Cout=%b Ov=%b want S=%h Cout=%b Ov=%b",
               nm, S, Cout, Ov, es, ec, eo);
    end
`ifdef BIT_8_ADDER_ZERO_FLAG_EN
    checks++;
    if (Z !== ((rst_n === 1'b0 || es == 8'h00) ? (es == 8'h00 && rst_n !== 1'b0) : 1'b0)) begin
      failures++;
      $display("FAIL %s_z: got Z=%b want Z=%b", nm, Z,
               (es == 8'h00 && rst_n !== 1'b0));
    end
`endif
  endtask

  // Model: plain integer arithmetic, signed range test for overflow.
  task automatic model(input logic [7:0] a, input logic [7:0] b,
                       input logic m, output logic [7:0] s,
                       output logic c, output logic o);
    int u;
    int sg;
    if (m) begin
      u  = int'(a) - int'(b);
      c  = (int'(a) >= int'(b));
      sg = int'($signed(a)) - int'($signed(b));
    end else begin
      u  = int'(a) + int'(b);
      c  = (u > 255);
      sg = int'($signed(a)) + int'($signed(b));
    end
    s = u[7:0];
    o = (sg > 127) || (sg < -128);
  endtask

  task automatic apply(input logic [7:0] a, input logic [7:0] b,
                       input logic m);
    @(negedge clk);
    A = a; B = b; mode = m;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[8];

  initial begin
    logic [7:0] es;
    logic       ec, eo;

    tbl[0] = '{8'h70, 8'h41, 1'b1, 8'h2F, 1'b1, 1'b0};
    tbl[1] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0};
    tbl[2] = '{8'h73, 8'h65, 1'b0, 8'hD8, 1'b0, 1'b1};
    tbl[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[4] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
    tbl[5] = '{8'h5A, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[7] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

    // Reset asserted with live operands, checked before any edge.
    rst_n = 1'b0;
    A = 8'hFF; B = 8'hFF; mode = 1'b0;
    #2;
    chk("reset_async", 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", 8'h00, 1'b0, 1'b0);

    // First edge after release registers the current operands.
    @(negedge clk);
    rst_n = 1'b1;
    A = 8'h70; B = 8'h41; mode = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_release", 8'h2F, 1'b1, 1'b0);

    foreach (tbl[i]) begin
      apply(tbl[i].a, tbl[i].b, tbl[i].m);
      chk($sformatf("vec%0d", i), tbl[i].s, tbl[i].c, tbl[i].o);
    end

    // Output holds while inputs change between edges.
    apply(8'h73, 8'h65, 1'b0);
    #2;
    A = 8'h01; B = 8'h01; mode = 1'b1;
    #1;
    chk("hold_between_edges", 8'hD8, 1'b0, 1'b1);

    // Mid-stream reset between edges clears at once.
    apply(8'hFF, 8'hFF, 1'b0);
    @(negedge clk);
    A = 8'h80; B = 8'h01; mode = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_async", 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("midreset_discard", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_resume", 8'h7F, 1'b1, 1'b1);

    // Back-to-back random operations.
    for (int i = 0; i < 200; i++) begin
      logic [7:0] ra, rb;
      logic       rm;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rm = 1'($urandom_range(0, 1));
      if (i % 25 == 0) rb = ra;
      model(ra, rb, rm, es, ec, eo);
      apply(ra, rb, rm);
      chk($sformatf("rand%0d", i), es, ec, eo);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
